// File: rtl/lcd1602_pkg.sv
// Shared definitions for the LCD1602 bus engines: read FSM states, RS encodings,
// busy-flag position and default bus timing (clocks at 50 MHz).
package lcd1602_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_EN_HI   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RECOVER = 3'd4
    } lcd_rd_state_e;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;
    localparam int   BF_BIT  = 7;

    localparam int unsigned LCD_SETUP_CYC   = 32'd3;
    localparam int unsigned LCD_EN_HIGH_CYC = 32'd25;
    localparam int unsigned LCD_HOLD_CYC    = 32'd2;
    localparam int unsigned LCD_EN_LOW_CYC  = 32'd25;
    localparam int unsigned LCD_POLL_MAX    = 32'd4096;

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b; else m = m;
        if (c > m) m = c; else m = m;
        if (d > m) m = d; else m = m;
        return m;
    endfunction

endpackage

// File: rtl/lcd1602_bus_reader_timer.sv
// Loadable phase down-counter: load N-1 on phase entry, expired_o marks the
// phase's last clock. Holds at zero instead of wrapping.
module lcd_phase_timer #(
    parameter int unsigned W = 6
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] count_q;

    // Phase count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end else begin
            count_q <= count_q;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/lcd1602_bus_reader.sv
// HD44780 read-cycle engine: timed status/data reads with optional busy polling.
// Define LCD_READ_4BIT_EN for 4-bit bus mode (two nibble cycles per byte).
module lcd1602_bus_reader
    import lcd1602_pkg::*;
#(
    parameter int unsigned SETUP_CYC   = LCD_SETUP_CYC,
    parameter int unsigned EN_HIGH_CYC = LCD_EN_HIGH_CYC,
    parameter int unsigned HOLD_CYC    = LCD_HOLD_CYC,
    parameter int unsigned EN_LOW_CYC  = LCD_EN_LOW_CYC,
    parameter int unsigned POLL_MAX    = LCD_POLL_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic       req_rs,
    input  logic       req_poll,
    output logic       ready,
    output logic       done,
    output logic [7:0] rdata,
    output logic       busy_flag,
    output logic [6:0] addr_cnt,
    output logic       timeout,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    input  logic [7:0] lcd_dat_i
);

    localparam int unsigned PH_W = $clog2(max4(SETUP_CYC, EN_HIGH_CYC, HOLD_CYC, EN_LOW_CYC)) + 1;
    localparam int unsigned PC_W = $clog2(POLL_MAX + 1);

    localparam logic [PH_W-1:0] LD_SETUP   = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0] LD_EN_HI   = PH_W'(EN_HIGH_CYC - 1);
    localparam logic [PH_W-1:0] LD_HOLD    = PH_W'(HOLD_CYC - 1);
    localparam logic [PH_W-1:0] LD_RECOVER = PH_W'(EN_LOW_CYC - 1);

    if (SETUP_CYC == 0 || EN_HIGH_CYC == 0 || HOLD_CYC == 0 ||
        EN_LOW_CYC == 0 || POLL_MAX == 0) begin : g_param_err
        $error("lcd1602_bus_reader: timing parameters and POLL_MAX must be nonzero");
    end

    lcd_rd_state_e   state_q, state_d;
    logic            rs_q, rs_d;
    logic            poll_q, poll_d;
    logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            busy_flag_q, busy_flag_d;
    logic [6:0]      addr_cnt_q, addr_cnt_d;
    logic            timeout_q, timeout_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_rw_q, lcd_rw_d;
    logic            lcd_en_q, lcd_en_d;
`ifdef LCD_READ_4BIT_EN
    logic            nib_q, nib_d;
    logic [3:0]      hi_nib_q, hi_nib_d;
`endif

    logic            load_s;
    logic [PH_W-1:0] load_val_s;
    logic            expired_s;
    logic            cap_s;
    logic [7:0]      byte_s;
    logic            finish_s;
    logic            more_s;

    lcd_phase_timer #(.W(PH_W)) u_timer (
        .clk_i      (clk),
        .rst_i      (reset),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .expired_o  (expired_s)
    );

    assign more_s = ((32'(poll_cnt_q) + 32'd1) < POLL_MAX);

    // Next-state, capture and poll decision logic
    always_comb begin
        state_d     = state_q;
        rs_d        = rs_q;
        poll_d      = poll_q;
        poll_cnt_d  = poll_cnt_q;
        rdata_d     = rdata_q;
        busy_flag_d = busy_flag_q;
        addr_cnt_d  = addr_cnt_q;
        timeout_d   = timeout_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        load_val_s  = '0;
        cap_s       = 1'b0;
        byte_s      = 8'h00;
        finish_s    = 1'b0;
`ifdef LCD_READ_4BIT_EN
        nib_d       = nib_q;
        hi_nib_d    = hi_nib_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d    = ST_SETUP;
                    rs_d       = req_rs;
                    poll_d     = req_poll & ~req_rs;
                    poll_cnt_d = '0;
                    timeout_d  = 1'b0;
                    load_s     = 1'b1;
                    load_val_s = LD_SETUP;
`ifdef LCD_READ_4BIT_EN
                    nib_d      = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (expired_s) begin
                    state_d    = ST_EN_HI;
                    load_s     = 1'b1;
                    load_val_s = LD_EN_HI;
                end else begin
                    state_d = ST_SETUP;
                end
            end
            ST_EN_HI: begin
                if (expired_s) begin
                    state_d    = ST_HOLD;
                    load_s     = 1'b1;
                    load_val_s = LD_HOLD;
`ifdef LCD_READ_4BIT_EN
                    if (!nib_q) begin
                        hi_nib_d = lcd_dat_i[7:4];
                    end else begin
                        byte_s = {hi_nib_q, lcd_dat_i[7:4]};
                        cap_s  = 1'b1;
                    end
`else
                    byte_s = lcd_dat_i;
                    cap_s  = 1'b1;
`endif
                end else begin
                    state_d = ST_EN_HI;
                end
            end
            ST_HOLD: begin
                if (expired_s) begin
                    state_d    = ST_RECOVER;
                    load_s     = 1'b1;
                    load_val_s = LD_RECOVER;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_RECOVER: begin
                if (expired_s) begin
`ifdef LCD_READ_4BIT_EN
                    if (!nib_q) begin
                        nib_d      = 1'b1;
                        state_d    = ST_SETUP;
                        load_s     = 1'b1;
                        load_val_s = LD_SETUP;
                    end else begin
                        nib_d    = 1'b0;
                        finish_s = 1'b1;
                    end
`else
                    finish_s = 1'b1;
`endif
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status reads also refresh the busy flag and address counter
        if (cap_s) begin
            rdata_d = byte_s;
            if (rs_q == RS_CMD) begin
                busy_flag_d = byte_s[BF_BIT];
                addr_cnt_d  = byte_s[BF_BIT-1:0];
            end else begin
                busy_flag_d = busy_flag_q;
            end
        end else begin
            rdata_d = rdata_q;
        end

        if (finish_s) begin
            if (poll_q && busy_flag_q && more_s) begin
                poll_cnt_d = poll_cnt_q + PC_W'(1);
                state_d    = ST_SETUP;
                load_s     = 1'b1;
                load_val_s = LD_SETUP;
            end else begin
                done_d    = 1'b1;
                timeout_d = poll_q & busy_flag_q;
                state_d   = ST_IDLE;
            end
        end else begin
            done_d = 1'b0;
        end

        ready_d  = (state_d == ST_IDLE);
        lcd_en_d = (state_d == ST_EN_HI);
        lcd_rw_d = (state_d == ST_SETUP) || (state_d == ST_EN_HI) || (state_d == ST_HOLD);
        lcd_rs_d = rs_d;
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rs_q        <= 1'b0;
            poll_q      <= 1'b0;
            poll_cnt_q  <= '0;
            rdata_q     <= 8'h00;
            busy_flag_q <= 1'b0;
            addr_cnt_q  <= 7'h00;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
            lcd_rs_q    <= 1'b0;
            lcd_rw_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
`ifdef LCD_READ_4BIT_EN
            nib_q       <= 1'b0;
            hi_nib_q    <= 4'h0;
`endif
        end else begin
            state_q     <= state_d;
            rs_q        <= rs_d;
            poll_q      <= poll_d;
            poll_cnt_q  <= poll_cnt_d;
            rdata_q     <= rdata_d;
            busy_flag_q <= busy_flag_d;
            addr_cnt_q  <= addr_cnt_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_rw_q    <= lcd_rw_d;
            lcd_en_q    <= lcd_en_d;
`ifdef LCD_READ_4BIT_EN
            nib_q       <= nib_d;
            hi_nib_q    <= hi_nib_d;
`endif
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign busy_flag = busy_flag_q;
    assign addr_cnt  = addr_cnt_q;
    assign timeout   = timeout_q;
    assign lcd_rs    = lcd_rs_q;
    assign lcd_rw    = lcd_rw_q;
    assign lcd_en    = lcd_en_q;

endmodule

// File: tb/tb_lcd1602_bus_reader.sv
// Directed self-checking bench for lcd1602_bus_reader (8-bit mode, POLL_MAX=8).
module tb_lcd1602_bus_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req = 1'b0;
    logic       req_rs = 1'b0;
    logic       req_poll = 1'b0;
    logic       ready, done, busy_flag, timeout, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] rdata;
    logic [6:0] addr_cnt;
    logic [7:0] lcd_dat_i;
    logic [7:0] bus_val = 8'h00;

    int n_checks = 0;
    int n_fail = 0;
    int en_rises = 0;
    int poll_base = 0;
    bit poll_sel = 1'b0;
    int cyc, enh, pre, post, rsbad, pulses, en0;
    bit got, seen;
    logic acc_ready, acc_rw, acc_to;

    lcd1602_bus_reader #(.POLL_MAX(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_rs    (req_rs),
        .req_poll  (req_poll),
        .ready     (ready),
        .done      (done),
        .rdata     (rdata),
        .busy_flag (busy_flag),
        .addr_cnt  (addr_cnt),
        .timeout   (timeout),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_dat_i (lcd_dat_i)
    );

    always #5 clk = ~clk;

    always @(posedge lcd_en) en_rises = en_rises + 1;

    // Poll scenario: busy for the first three EN pulses, then ready at address 0x12
    always_comb begin
        if (poll_sel) lcd_dat_i = ((en_rises - poll_base) <= 3) ? 8'h80 : 8'h12;
        else          lcd_dat_i = bus_val;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to done, profiling the bus cycle
    task automatic run(input logic rs, input logic poll, input int maxc, input bit spam);
        req = 1'b1; req_rs = rs; req_poll = poll;
        en0 = en_rises;
        tick();
        req = 1'b0;
        acc_ready = ready; acc_rw = lcd_rw; acc_to = timeout;
        cyc = 0; enh = 0; pre = 0; post = 0; rsbad = 0; seen = 1'b0; got = 1'b0;
        forever begin
            if (lcd_en) begin enh++; seen = 1'b1; end
            else if (lcd_rw) begin if (seen) post++; else pre++; end
            if (lcd_rs !== rs) rsbad++;
            if (done) begin got = 1'b1; break; end
            if (cyc >= maxc) break;
            if (spam && cyc == 10) begin req = 1'b1; req_rs = ~rs; end
            else req = 1'b0;
            tick();
            cyc++;
        end
        req = 1'b0;
        pulses = en_rises - en0;
        chk("done_seen", got, 1);
    endtask

    initial begin
        tick(); tick();
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_rw_en", {lcd_rs, lcd_rw, lcd_en}, 3'b000);
        chk("rst_status", {busy_flag, addr_cnt, timeout}, 9'h000);
        reset = 1'b0;
        tick();

        // Status read 0x85 with a stray req mid-cycle
        bus_val = 8'h85;
        run(1'b0, 1'b0, 200, 1'b1);
        chk("st_latency", cyc, 55);
        chk("st_en_width", enh, 25);
        chk("st_setup", pre, 3);
        chk("st_hold", post, 2);
        chk("st_pulses", pulses, 1);
        chk("st_rdata", rdata, 8'h85);
        chk("st_bf", busy_flag, 1);
        chk("st_addr", addr_cnt, 7'h05);
        chk("st_rw_idle", lcd_rw, 0);
        chk("st_ready", ready, 1);
        chk("st_timeout", timeout, 0);
        tick();
        chk("st_done_pulse", done, 0);

        // Data read 0x41 keeps status fields
        bus_val = 8'h41;
        run(1'b1, 1'b0, 200, 1'b0);
        chk("dt_latency", cyc, 55);
        chk("dt_rdata", rdata, 8'h41);
        chk("dt_bf_kept", busy_flag, 1);
        chk("dt_addr_kept", addr_cnt, 7'h05);
        chk("dt_rs_high", rsbad, 0);

        // Back-to-back status read accepted in the done clock
        run(1'b0, 1'b0, 200, 1'b0);
        chk("b2b_acc_ready", acc_ready, 0);
        chk("b2b_acc_rw", acc_rw, 1);
        chk("b2b_latency", cyc, 55);
        chk("b2b_bf", busy_flag, 0);
        chk("b2b_addr", addr_cnt, 7'h41);

        // Poll: busy three times, then ready
        tick();
        poll_base = en_rises;
        poll_sel = 1'b1;
        run(1'b0, 1'b1, 1000, 1'b0);
        chk("poll_pulses", pulses, 4);
        chk("poll_latency", cyc, 220);
        chk("poll_bf", busy_flag, 0);
        chk("poll_addr", addr_cnt, 7'h12);
        chk("poll_timeout", timeout, 0);
        tick();
        chk("poll_done_once", done, 0);
        poll_sel = 1'b0;

        // Poll timeout with bus stuck busy
        bus_val = 8'hFF;
        run(1'b0, 1'b1, 1000, 1'b0);
        chk("to_pulses", pulses, 8);
        chk("to_latency", cyc, 440);
        chk("to_flag", timeout, 1);
        chk("to_bf", busy_flag, 1);

        // Next request clears timeout; poll ignored on data read
        run(1'b1, 1'b1, 1000, 1'b0);
        chk("to_cleared", acc_to, 0);
        chk("rspoll_pulses", pulses, 1);
        chk("rspoll_timeout", timeout, 0);

        // Reset in EN_HI acts without a clock edge
        bus_val = 8'h33;
        req = 1'b1; req_rs = 1'b0; req_poll = 1'b0;
        tick();
        req = 1'b0;
        repeat (10) tick();
        chk("mid_en_high", lcd_en, 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_en", lcd_en, 0);
        chk("mid_rst_rw", lcd_rw, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_rdata", rdata, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        run(1'b0, 1'b0, 200, 1'b0);
        chk("post_rst_latency", cyc, 55);
        chk("post_rst_rdata", rdata, 8'h33);
        chk("post_rst_addr", addr_cnt, 7'h33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd1602_bus_reader.md
Name: lcd1602_bus_reader

Overview:
- Read-side engine for the HD44780/LCD1602 parallel bus; complements the existing write-only LCD driver.
- Issues timed read cycles with RW=1:
  - RS=0 reads busy flag and address counter.
  - RS=1 reads the DDRAM/CGRAM byte at the address counter.
- Optional poll mode repeats status reads until BF=0, with a timeout. The write driver can then wait on "not busy" instead of fixed delays.
- Sits between the LCD command sequencer and the LCD pins. An external mux, outside this block, selects reader or writer.

Parameters:
- SETUP_CYC, 3: clocks RS/RW held stable before EN rises (tAS ≥ 40 ns at 50 MHz).
- EN_HIGH_CYC, 25: clocks EN held high (≥ 450 ns). Data is sampled on the last of these clocks.
- HOLD_CYC, 2: clocks RS/RW held after EN falls (tAH).
- EN_LOW_CYC, 25: minimum EN-low recovery clocks before the next EN rise or return to idle.
- POLL_MAX, 4096: maximum status reads in one poll request before timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  start request; sampled only when ready=1
- req_rs  in  1  0 = status read, 1 = data read; latched with req
- req_poll  in  1  1 = repeat status reads until BF=0; ignored when req_rs=1
- ready  out  1  idle, accepting req
- done  out  1  one-clock pulse when a request completes
- rdata  out  8  last captured byte; held until the next capture
- busy_flag  out  1  rdata[7] of the last status read
- addr_cnt  out  7  rdata[6:0] of the last status read
- timeout  out  1  set with done when a poll hit POLL_MAX; cleared on the next accepted req
- lcd_rs  out  1  LCD RS
- lcd_rw  out  1  LCD RW; 1 only while a cycle is active
- lcd_en  out  1  LCD E
- lcd_dat_i  in  8  LCD data bus (input only)

Behaviour:
- Reset values (async, immediate): ready=1, done=0, rdata=0, busy_flag=0, addr_cnt=0, timeout=0, lcd_rs=0, lcd_rw=0, lcd_en=0, state IDLE, counters 0.
- Reset mid-cycle truncates EN at once. This is accepted; the sequencer reinitialises the LCD after reset.
- FSM states: IDLE, SETUP, EN_HI, HOLD, RECOVER.
- IDLE:
  - ready=1 and lcd_rw=0.
  - req=1 latches req_rs, the poll flag (req_poll & ~req_rs) and clears timeout. Next state SETUP, poll count = 0.
  - req while ready=0 is ignored; it is neither queued nor latched.
- SETUP:
  - lcd_rs = latched rs, lcd_rw=1, lcd_en=0, for SETUP_CYC clocks. Then EN_HI.
- EN_HI:
  - lcd_en=1 for EN_HIGH_CYC clocks.
  - On the last clock, lcd_dat_i is registered into rdata.
  - If rs=0, busy_flag and addr_cnt also update from the same sample.
  - The bus is stable while E is high, so there is a single capture register and no synchroniser.
- HOLD:
  - lcd_en=0, RS/RW held, for HOLD_CYC clocks. Then RECOVER.
- RECOVER:
  - lcd_rw=0, lcd_rs held, lcd_en=0, for EN_LOW_CYC clocks.
  - Poll active, captured BF=1 and poll count+1 < POLL_MAX: increment poll count, go to SETUP.
  - Poll active, BF=1 and count+1 = POLL_MAX: timeout=1, done=1, go to IDLE.
  - Otherwise: done=1, go to IDLE.
- done is registered and high in the first IDLE clock. ready is also 1 in that clock, so req may be accepted that same clock (back-to-back).
- Latency, single read: SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+EN_LOW_CYC clocks from req accept to done. Defaults give 55 clocks = 1.1 µs ≥ tcycE 1000 ns.
- Phase counter width is $clog2 of the largest timing parameter, +1. Poll counter width is $clog2(POLL_MAX+1). Counters never wrap.
- Parameter values of 0 are illegal; they are checked by elaboration assertion.
- Poll with BF=0 on the first read: done after exactly one cycle, timeout=0.

Optional Feature:
- Macro LCD_READ_4BIT_EN.
- Defined: 4-bit bus mode. Each read performs two full SETUP/EN_HI/HOLD/RECOVER sequences.
  - First sample captures the high nibble from lcd_dat_i[7:4]; second captures the low nibble from lcd_dat_i[7:4].
  - rdata, busy_flag and addr_cnt update only after the second nibble.
  - Poll decision uses the assembled byte. Latency doubles.
- Undefined: 8-bit mode as above; lcd_dat_i[3:0] used.

Decomposition:
- Package lcd1602_pkg:
  - FSM state enum.
  - RS_CMD=0, RS_DATA=1.
  - BF_BIT=7.
  - Default timing constants, shared with the write driver.
- One sub-module, lcd_phase_timer: loadable down-counter with a load value input, start pulse and expired flag. It is reused for every phase.

Test Plan:
- Status read, bus 8'h85 during EN high → after 55 clks done=1, rdata=8'h85, busy_flag=1, addr_cnt=7'h05, lcd_rw back to 0, timeout=0.
- Data read req_rs=1, bus 8'h41 → rdata=8'h41; busy_flag/addr_cnt keep previous values; lcd_rs=1 throughout SETUP..RECOVER.
- Poll with bus 8'h80 for the first 3 EN pulses then 8'h12 → exactly 4 EN pulses, done once, busy_flag=0, addr_cnt=7'h12, timeout=0.
- Poll with POLL_MAX=8 and bus held 8'hFF → exactly 8 EN pulses, done with timeout=1; next accepted req clears timeout.
- Timing check: EN high width = 25 clks; RS/RW stable ≥3 clks before EN rise and ≥2 clks after EN fall; req during busy ignored; back-to-back req in the done clock accepted.
- Reset asserted in EN_HI → lcd_en, lcd_rw and ready reach reset values in the same clock without waiting for an edge; rdata=0; a subsequent req works normally.
